// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, widths and BCD step function for the score counter
package game_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // Next value of one decade; used by the digit register and by the display prefetch.
  function automatic logic [BCD_W-1:0] bcd_next(
    input logic [BCD_W-1:0] q,
    input logic             clr,
    input logic             en,
    input logic             hold
  );
    logic [BCD_W-1:0] r;
    r = q;
    if (clr) begin
      r = '0;
    end else if (en && !hold) begin
      r = (q >= BCD_MAX_DIGIT) ? '0 : q + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decimal decade with synchronous clear, carry in/out and hold
module bcd_digit
  import game_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             sat_i,
  output logic [BCD_W-1:0] q_o,
  output logic             co_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= '0;
    end else begin
      q_o <= bcd_next(q_o, clr_i, en_i, sat_i);
    end
  end

  assign co_o = en_i & (q_o == BCD_MAX_DIGIT);

endmodule

// File: rtl/game_score_bcd.sv
// rtl/game_score_bcd.sv - three-digit BCD game score with game-over freeze, high score and display select
module game_score_bcd
  import game_pkg::*;
#(
  parameter int SAT_EN = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       inc_i,
  input  logic       over_i,
  input  logic       clr_i,
  input  logic       show_hi_i,
  output logic [3:0] dat1_o,
  output logic [3:0] dat2_o,
  output logic [3:0] dat3_o,
  output logic       sat_o,
  output logic       over_o,
  output logic       new_hi_o
);

  state_t           state, state_nxt;
  logic             inc_d, over_d;
  logic             inc_pulse, over_pulse;
  logic             cnt_en, capture;
  logic             c1, c2, c3;
  logic             hold, all_nines, beats;
  logic [BCD_W-1:0] sc1, sc2, sc3;
  logic [BCD_W-1:0] hi1, hi2, hi3;
  logic [BCD_W-1:0] sc1_nxt, sc2_nxt, sc3_nxt;
  logic [BCD_W-1:0] hi1_nxt, hi2_nxt, hi3_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inc_d  <= 1'b0;
      over_d <= 1'b0;
    end else begin
      inc_d  <= inc_i;
      over_d <= over_i;
    end
  end

  assign inc_pulse  = inc_i & ~inc_d;
  assign over_pulse = over_i & ~over_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // clr_i outranks everything; game over outranks a same-cycle increment.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_RUN: begin
        if (!clr_i) begin
          if (over_pulse) begin
            capture   = 1'b1;
            state_nxt = ST_OVER;
          end else if (inc_pulse) begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (clr_i) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // c3 fires only when an increment meets 999, so it doubles as the overflow detect.
  assign hold = (SAT_EN != 0) && c3;

  bcd_digit u_ones (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .en_i    (cnt_en),
    .sat_i   (hold),
    .q_o     (sc1),
    .co_o    (c1)
  );

  bcd_digit u_tens (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .en_i    (c1),
    .sat_i   (hold),
    .q_o     (sc2),
    .co_o    (c2)
  );

  bcd_digit u_hund (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .en_i    (c2),
    .sat_i   (hold),
    .q_o     (sc3),
    .co_o    (c3)
  );

  assign all_nines = (sc1 == BCD_MAX_DIGIT) && (sc2 == BCD_MAX_DIGIT) &&
                     (sc3 == BCD_MAX_DIGIT);
  assign beats     = {sc3, sc2, sc1} > {hi3, hi2, hi1};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hi1      <= '0;
      hi2      <= '0;
      hi3      <= '0;
      new_hi_o <= 1'b0;
    end else begin
      if (capture && beats) begin
        hi1 <= sc1;
        hi2 <= sc2;
        hi3 <= sc3;
      end
      if (clr_i) begin
        new_hi_o <= 1'b0;
      end else if (capture && beats) begin
        new_hi_o <= 1'b1;
      end
    end
  end

  // Display registers load next-cycle values so a count shows right after its edge.
  assign sc1_nxt = bcd_next(sc1, clr_i, cnt_en, hold);
  assign sc2_nxt = bcd_next(sc2, clr_i, c1, hold);
  assign sc3_nxt = bcd_next(sc3, clr_i, c2, hold);
  assign hi1_nxt = (capture && beats) ? sc1 : hi1;
  assign hi2_nxt = (capture && beats) ? sc2 : hi2;
  assign hi3_nxt = (capture && beats) ? sc3 : hi3;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dat1_o <= '0;
      dat2_o <= '0;
      dat3_o <= '0;
    end else begin
      dat1_o <= show_hi_i ? hi1_nxt : sc1_nxt;
      dat2_o <= show_hi_i ? hi2_nxt : sc2_nxt;
      dat3_o <= show_hi_i ? hi3_nxt : sc3_nxt;
    end
  end

  assign sat_o  = all_nines;
  assign over_o = (state == ST_OVER);

endmodule

// File: tb/tb_game_score_bcd.sv
// tb/tb_game_score_bcd.sv - self-checking bench for game_score_bcd, saturating and wrapping builds
module tb_game_score_bcd;

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       inc_i = 1'b0;
  logic       over_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       show_hi_i = 1'b0;
  logic [3:0] s_dat1, s_dat2, s_dat3, w_dat1, w_dat2, w_dat3;
  logic       s_sat, s_over, s_newhi, w_sat, w_over, w_newhi;

  game_score_bcd #(.SAT_EN(1)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n_i), .inc_i(inc_i), .over_i(over_i), .clr_i(clr_i),
    .show_hi_i(show_hi_i), .dat1_o(s_dat1), .dat2_o(s_dat2), .dat3_o(s_dat3),
    .sat_o(s_sat), .over_o(s_over), .new_hi_o(s_newhi)
  );

  game_score_bcd #(.SAT_EN(0)) dut_wrap (
    .clk_i(clk), .rst_n_i(rst_n_i), .inc_i(inc_i), .over_i(over_i), .clr_i(clr_i),
    .show_hi_i(show_hi_i), .dat1_o(w_dat1), .dat2_o(w_dat2), .dat3_o(w_dat3),
    .sat_o(w_sat), .over_o(w_over), .new_hi_o(w_newhi)
  );

  always #5 clk = ~clk;

  logic [14:0] act [2];
  assign act[0] = {s_dat3, s_dat2, s_dat1, s_sat, s_over, s_newhi};
  assign act[1] = {w_dat3, w_dat2, w_dat1, w_sat, w_over, w_newhi};

  int checks = 0;
  int fails  = 0;
  bit cur_show = 1'b0;

  // Reference model: plain integers per build (index 0 saturating, 1 wrapping).
  int m_score [2];
  int m_high  [2];
  int m_disp  [2];
  bit m_over  [2];
  bit m_newhi [2];
  bit m_inc_d, m_over_d;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [14:0] exp_vec(input int k);
    return {to_bcd(m_disp[k]), (m_score[k] == 999), m_over[k], m_newhi[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_score[k] = 0; m_high[k] = 0; m_disp[k] = 0; m_over[k] = 0; m_newhi[k] = 0;
    end
    m_inc_d = 0;
    m_over_d = 0;
  endtask

  task automatic model_edge(input bit inc, input bit ovr, input bit clr, input bit show);
    bit ip, op;
    ip = inc && !m_inc_d;
    op = ovr && !m_over_d;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_score[k] = 0;
        m_newhi[k] = 0;
        m_over[k]  = 0;
      end else if (!m_over[k]) begin
        if (op) begin
          if (m_score[k] > m_high[k]) begin
            m_high[k]  = m_score[k];
            m_newhi[k] = 1;
          end
          m_over[k] = 1;
        end else if (ip) begin
          if (k == 0) m_score[k] = (m_score[k] >= 999) ? 999 : m_score[k] + 1;
          else        m_score[k] = (m_score[k] + 1) % 1000;
        end
      end
      m_disp[k] = show ? m_high[k] : m_score[k];
    end
    m_inc_d  = inc;
    m_over_d = ovr;
  endtask

  task automatic step(input bit inc, input bit ovr, input bit clr);
    @(negedge clk);
    inc_i = inc; over_i = ovr; clr_i = clr; show_hi_i = cur_show;
    @(posedge clk);
    model_edge(inc, ovr, clr, cur_show);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n_i = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== exp_vec(k)) begin
        fails++;
        $display("FAIL reset dut%0d got %h expected %h", k, act[k], exp_vec(k));
      end
    end
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  task automatic test_single_pulses();
    pulses(12);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h012, 3'b000})) begin
        fails++;
        $display("FAIL twelve_pulses dut%0d got %h expected %h", k, act[k], {12'h012, 3'b000});
      end
    end
  endtask

  task automatic test_held_inc();
    step(0, 0, 1);
    for (int i = 0; i < 50; i++) step(1, 0, 0);
    step(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== exp_vec(k) || m_score[k] != 1) begin
        fails++;
        $display("FAIL held_inc dut%0d got %h expected %h", k, act[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 1);
    pulses(998);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h998, 3'b000})) begin
        fails++;
        $display("FAIL preload_998 dut%0d got %h expected %h", k, act[k], {12'h998, 3'b000});
      end
    end
    pulses(1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h999, 3'b100})) begin
        fails++;
        $display("FAIL reach_999 dut%0d got %h expected %h", k, act[k], {12'h999, 3'b100});
      end
    end
    pulses(2);
    checks++;
    if (act[0] !== 15'({12'h999, 3'b100})) begin
      fails++;
      $display("FAIL saturate_999 got %h expected %h", act[0], {12'h999, 3'b100});
    end
    checks++;
    if (act[1] !== 15'({12'h001, 3'b000})) begin
      fails++;
      $display("FAIL wrap_001 got %h expected %h", act[1], {12'h001, 3'b000});
    end
  endtask

  task automatic test_game_over();
    step(0, 0, 1);
    pulses(37);
    step(0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h037, 3'b011})) begin
        fails++;
        $display("FAIL over_at_37 dut%0d got %h expected %h", k, act[k], {12'h037, 3'b011});
      end
    end
    cur_show = 1'b1;
    step(0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h037, 3'b011}) || m_high[k] != 37) begin
        fails++;
        $display("FAIL high_shows_37 dut%0d got %h expected %h", k, act[k], {12'h037, 3'b011});
      end
    end
    cur_show = 1'b0;
    pulses(5);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h037, 3'b011})) begin
        fails++;
        $display("FAIL frozen_37 dut%0d got %h expected %h", k, act[k], {12'h037, 3'b011});
      end
    end
  endtask

  task automatic test_lower_and_equal();
    step(0, 0, 1);
    pulses(20);
    step(0, 1, 0);
    cur_show = 1'b1;
    step(0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h037, 3'b010})) begin
        fails++;
        $display("FAIL lower_game dut%0d got %h expected %h", k, act[k], {12'h037, 3'b010});
      end
    end
    cur_show = 1'b0;
    step(0, 0, 1);
    pulses(37);
    step(0, 1, 0);
    cur_show = 1'b1;
    step(0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h037, 3'b010})) begin
        fails++;
        $display("FAIL equal_game dut%0d got %h expected %h", k, act[k], {12'h037, 3'b010});
      end
    end
    cur_show = 1'b0;
  endtask

  task automatic test_clr_priority();
    step(0, 0, 1);
    pulses(4);
    step(1, 1, 1);
    step(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h000, 3'b000})) begin
        fails++;
        $display("FAIL clr_priority dut%0d got %h expected %h", k, act[k], {12'h000, 3'b000});
      end
    end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 1);
    pulses(9);
    step(1, 1, 0);
    pulses(3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'({12'h009, 3'b010})) begin
        fails++;
        $display("FAIL inc_over_same_cycle dut%0d got %h expected %h", k, act[k], {12'h009, 3'b010});
      end
    end
    @(negedge clk);
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'd0) begin
        fails++;
        $display("FAIL reset_mid_over dut%0d got %h expected %h", k, act[k], 15'd0);
      end
    end
    @(negedge clk);
    inc_i = 0; over_i = 0; clr_i = 0;
    rst_n_i = 1'b1;
    cur_show = 1'b1;
    pulses(2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== 15'd0) begin
        fails++;
        $display("FAIL high_cleared_by_reset dut%0d got %h expected %h", k, act[k], 15'd0);
      end
    end
    cur_show = 1'b0;
  endtask

  task automatic test_random();
    bit inc, ovr, clr;
    for (int i = 0; i < 600; i++) begin
      inc = 1'($urandom_range(0, 1));
      ovr = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 19) == 0);
      cur_show = 1'($urandom_range(0, 1));
      step(inc, ovr, clr);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== exp_vec(k)) begin
          fails++;
          $display("FAIL random cycle %0d dut%0d got %h expected %h", i, k, act[k], exp_vec(k));
        end
      end
    end
    cur_show = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pulses();
    test_held_inc();
    test_saturate();
    test_game_over();
    test_lower_and_equal();
    test_clr_priority();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
